// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataRAM between the CPU MEM stage and a
// debug/loader port. The CPU wins contention until the debug port has lost
// MAX_WAIT consecutive cycles; the next cycle the debug port is forced onto
// the RAM and the CPU is stalled for that one cycle.
//
// Handshake: dbg_req is held by the requester until it sees dbg_gnt=1, which is
// the cycle the access is performed. A granted read returns its data one cycle
// later on dbg_rdata, qualified by a single-cycle dbg_rvalid pulse. A granted
// write completes in the grant cycle and produces no dbg_rvalid. The CPU has no
// ready signal; cpu_stall=1 means its access was not performed and must be held.
//
// state_o exposes the arbitration FSM: 2'd0 IDLE, 2'd1 WAIT, 2'd2 FORCE.
//
// Optional macro DMEM_ARB_STATS_EN adds saturating stall_cnt / force_cnt outputs.
module dmem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_spo,
  output logic [1:0]        state_o
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       force_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        cnt_inc;
  logic              both_req;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              dbg_rvalid_q;

  assign both_req = cpu_req & dbg_req;
  assign cnt_inc  = wait_cnt_q + 8'd1;

  // State register: arbitration state and lost-cycle counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state: count consecutive contention cycles lost by debug, force after MAX_WAIT.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (both_req) begin
          wait_cnt_d = cnt_inc;
          state_d    = (cnt_inc == MAX_WAIT_C) ? S_FORCE : S_WAIT;
        end else begin
          wait_cnt_d = 8'd0;
          state_d    = S_IDLE;
        end
      end
      S_FORCE: begin
        wait_cnt_d = 8'd0;
        state_d    = S_IDLE;
      end
      default: begin
        wait_cnt_d = 8'd0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Outputs: grant decision, stall, and RAM port mux; RAM writes are blocked during reset.
  always_comb begin
    dbg_gnt   = dbg_req & (~cpu_req | (state_q == S_FORCE));
    cpu_stall = cpu_req & dbg_gnt;
    cpu_rdata = ram_spo;
    state_o   = state_q;
    if (dbg_gnt) begin
      ram_a  = dbg_addr;
      ram_d  = dbg_wdata;
      ram_we = reset & dbg_we;
    end else begin
      ram_a  = cpu_addr;
      ram_d  = cpu_wdata;
      ram_we = reset & cpu_we & cpu_req;
    end
  end

  // Debug read return: capture RAM data on a granted read, pulse rvalid next cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else if (dbg_gnt && !dbg_we) begin
      dbg_rdata_q  <= ram_spo;
      dbg_rvalid_q <= 1'b1;
    end else begin
      dbg_rvalid_q <= 1'b0;
    end
  end

  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] force_cnt_q;
  logic        force_entry;

  assign force_entry = (state_d == S_FORCE) && (state_q != S_FORCE);

  // Statistics: saturating counts of CPU stall cycles and FORCE entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
      force_cnt_q <= 16'd0;
    end else begin
      if (cpu_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (force_entry && (force_cnt_q != 16'hFFFF)) force_cnt_q <= force_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign force_cnt = force_cnt_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port DataRAM (6-bit word address, 32-bit data, async read, sync write) between two requesters:
  - the CPU MEM stage;
  - a debug/loader port used for program load and memory inspection.
- CPU normally has priority. A starvation counter forces one debug access after MAX_WAIT lost cycles, stalling the CPU for that cycle.
- Sits between the EX_MEM pipeline register and DataRAM; cpu_stall feeds the pipeline stall logic.

Parameters:
- ADDR_W, 6, word address width (DataRAM a port)
- DATA_W, 32, data width
- MAX_WAIT, 4, consecutive lost arbitration cycles before debug is forced; legal range 1..255

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  MEM stage accesses memory this cycle (MemRead or MemWrite)
- cpu_we  in  1  CPU write strobe
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data (combinational from ram_spo)
- cpu_stall  out  1  CPU access not performed this cycle; pipeline must hold
- dbg_req  in  1  debug request, held until granted
- dbg_we  in  1  debug write strobe
- dbg_addr  in  ADDR_W  debug word address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rdata  out  DATA_W  registered debug read data
- dbg_rvalid  out  1  dbg_rdata valid, one-cycle pulse
- ram_a  out  ADDR_W  to DataRAM a
- ram_d  out  DATA_W  to DataRAM d
- ram_we  out  1  to DataRAM we
- ram_spo  in  DATA_W  from DataRAM spo

Behaviour:
- Reset (reset=0 at clk edge):
  - state=IDLE, wait_cnt=0, dbg_rdata=0, dbg_rvalid=0.
  - Combinational outputs follow the IDLE rules below.
- States: IDLE (no debug contention), WAIT (debug losing to CPU, counting), FORCE (debug owns RAM this cycle).
- Grant, combinational, same cycle:
  - dbg_req=1, cpu_req=0 → debug granted in any state.
  - Both requesting in IDLE/WAIT → CPU granted.
  - Both requesting in FORCE → debug granted, cpu_stall=1.
  - cpu_stall=1 only when cpu_req=1 and debug is granted.
- RAM mux:
  - Debug granted: ram_a=dbg_addr, ram_d=dbg_wdata, ram_we=dbg_we.
  - Otherwise: CPU signals, with ram_we=cpu_we&cpu_req.
  - No request: ram_we=0.
- cpu_rdata=ram_spo always; load data arrives in the same cycle.
- Transitions:
  - IDLE, both requesting → WAIT, wait_cnt=1.
  - WAIT, both requesting → wait_cnt+1; when the incremented value equals MAX_WAIT → FORCE.
  - WAIT, debug granted (CPU idle) or dbg_req=0 → IDLE, wait_cnt=0.
  - FORCE → IDLE unconditionally, wait_cnt=0.
  - FORCE with dbg_req=0: no grant, no stall.
- With MAX_WAIT=1: IDLE with both requesting goes directly to FORCE.
- Debug read: when dbg_gnt=1 and dbg_we=0, dbg_rdata<=ram_spo and dbg_rvalid<=1 next cycle. Otherwise dbg_rvalid<=0 and dbg_rdata holds.
- Debug write: completes in the dbg_gnt cycle; no rvalid.
- Requester may drop dbg_req after the dbg_gnt cycle. If held, the next debug access follows the normal rules.
- Reset mid-FORCE or mid-WAIT: return to IDLE with no RAM write that cycle (ram_we=0 while reset=0).

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0]: counts cycles with cpu_stall=1, saturating at 16'hFFFF, cleared by reset.
  - Adds output force_cnt [15:0]: counts FORCE entries, saturating at 16'hFFFF, cleared by reset.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Reset: hold reset=0 with dbg_req=1, cpu_req=1, cpu_we=1 → ram_we=0, dbg_rvalid=0, dbg_rdata=0; after release, state IDLE.
- CPU-only: cpu_req=1, cpu_we=1, addr 5, data 32'hDEADBEEF, then read addr 5 → cpu_rdata=32'hDEADBEEF same cycle; cpu_stall never 1.
- Debug-only read: preload addr 3=32'h12345678; dbg_req=1, dbg_we=0, addr 3 → dbg_gnt=1 same cycle; dbg_rvalid=1 and dbg_rdata=32'h12345678 next cycle.
- Starvation (MAX_WAIT=4): cpu_req and dbg_req held high for 10 cycles → dbg_gnt=1 and cpu_stall=1 in cycles 5 and 10 only; CPU granted all other cycles.
- Contention abort: both requesting 2 cycles, then dbg_req=0 → state IDLE, wait_cnt=0; a new conflict needs another 4 lost cycles before FORCE.
- Stats (DMEM_ARB_STATS_EN): repeat the starvation scenario → stall_cnt=2, force_cnt=2.
